// File: rtl/or1200_chk_pkg.sv
// Shared types and defaults for the checker alarm controller.
// Holds the FSM encoding and the lowest-index priority encoder.
package or1200_chk_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ALARM = 2'd2
  } state_t;

  localparam int DEF_NUM_CHK  = 8;
  localparam int DEF_PERSIST  = 2;
  localparam int DEF_BOOT_CYC = 4;
  localparam int DEF_CNT_W    = 8;

  // Scans high to low so the last hit is the lowest set bit
  function automatic logic [4:0] lowest_idx(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/or1200_alarm_persist.sv
// Per-channel persistence counter for checker fail qualification.
// Counts consecutive active fails, saturating at PERSIST.
module or1200_alarm_persist
  import or1200_chk_pkg::*;
#(
  parameter int PERSIST = DEF_PERSIST
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic fail,
  output logic qual
);

  localparam logic [3:0] PMAX = 4'(PERSIST);
  localparam logic [3:0] QLIM = 4'(PERSIST - 1);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || hold) begin
      cnt <= '0;
    end else if (fail) begin
      if (cnt != PMAX) cnt <= cnt + 4'd1;
    end else begin
      cnt <= '0;
    end
  end

  // This sample is the PERSIST-th consecutive fail
  assign qual = fail && (cnt >= QLIM);

endmodule

// File: rtl/or1200_alarm_ctrl.sv
// Alarm controller: qualifies persistent checker failures and
// latches a level alarm with sticky fault record and event count.
module or1200_alarm_ctrl
  import or1200_chk_pkg::*;
#(
  parameter int NUM_CHK  = DEF_NUM_CHK,
  parameter int PERSIST  = DEF_PERSIST,
  parameter int BOOT_CYC = DEF_BOOT_CYC,
  parameter int CNT_W    = DEF_CNT_W,
  localparam int IDX_W   = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CHK-1:0] chk_ok,
  input  logic [NUM_CHK-1:0] chk_mask,
  input  logic               ack,
  output logic               alarm,
  output logic               alarm_pulse,
  output logic [NUM_CHK-1:0] fault_vec,
  output logic [IDX_W-1:0]   first_idx,
  output logic [CNT_W-1:0]   alarm_cnt
);

  localparam logic [7:0] BOOT_LAST =
    8'((BOOT_CYC == 0) ? 0 : BOOT_CYC - 1);

  state_t             state;
  state_t             state_n;
  logic [7:0]         boot_cnt;
  logic [7:0]         boot_cnt_n;
  logic [NUM_CHK-1:0] fail;
  logic [NUM_CHK-1:0] qual;
  logic [NUM_CHK-1:0] fault_n;
  logic [IDX_W-1:0]   idx_n;
  logic               pulse_n;
  logic [CNT_W-1:0]   cnt_n;
  logic [31:0]        qual32;
  logic [4:0]         low;
  logic               in_boot;

  assign fail    = ~chk_ok & ~chk_mask;
  assign in_boot = (state == ST_BOOT);

  for (genvar i = 0; i < NUM_CHK; i++) begin : g_ch
    or1200_alarm_persist #(
      .PERSIST(PERSIST)
    ) u_persist (
      .clk (clk),
      .rst (rst),
      .hold(in_boot),
      .fail(fail[i]),
      .qual(qual[i])
    );
  end

  always_comb begin
    qual32 = '0;
    qual32[NUM_CHK-1:0] = qual;
    low = lowest_idx(qual32);
  end

  always_comb begin
    state_n    = state;
    boot_cnt_n = boot_cnt;
    fault_n    = fault_vec;
    idx_n      = first_idx;
    pulse_n    = 1'b0;
    cnt_n      = alarm_cnt;
    unique case (state)
      ST_BOOT: begin
        if (boot_cnt >= BOOT_LAST) begin
          state_n = ST_ARMED;
        end else begin
          boot_cnt_n = boot_cnt + 8'd1;
        end
      end
      ST_ARMED: begin
        if (|qual) begin
          state_n = ST_ALARM;
          fault_n = fault_vec | qual;
          idx_n   = low[IDX_W-1:0];
          pulse_n = 1'b1;
          if (alarm_cnt != '1) cnt_n = alarm_cnt + 1'b1;
        end
      end
      ST_ALARM: begin
        // A fresh qualification outranks the acknowledge
        if (|qual) begin
          fault_n = fault_vec | qual;
        end else if (ack) begin
          state_n = ST_ARMED;
          fault_n = '0;
          idx_n   = '0;
        end
      end
      default: state_n = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_BOOT;
      boot_cnt    <= '0;
      alarm       <= 1'b0;
      alarm_pulse <= 1'b0;
      fault_vec   <= '0;
      first_idx   <= '0;
      alarm_cnt   <= '0;
    end else begin
      state       <= state_n;
      boot_cnt    <= boot_cnt_n;
      alarm       <= (state_n == ST_ALARM);
      alarm_pulse <= pulse_n;
      fault_vec   <= fault_n;
      first_idx   <= idx_n;
      alarm_cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_or1200_alarm_ctrl.sv
// Directed bench for or1200_alarm_ctrl (default and CNT_W=2 builds).
// Both instances share stimulus; the second checks count saturation.
module tb_or1200_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] chk_ok;
  logic [7:0] chk_mask;
  logic       ack;
  logic       alarm;
  logic       alarm_pulse;
  logic [7:0] fault_vec;
  logic [2:0] first_idx;
  logic [7:0] alarm_cnt;
  logic       alarm2;
  logic       alarm_pulse2;
  logic [7:0] fault_vec2;
  logic [2:0] first_idx2;
  logic [1:0] alarm_cnt2;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  or1200_alarm_ctrl dut (
    .clk(clk), .rst(rst), .chk_ok(chk_ok), .chk_mask(chk_mask),
    .ack(ack), .alarm(alarm), .alarm_pulse(alarm_pulse),
    .fault_vec(fault_vec), .first_idx(first_idx),
    .alarm_cnt(alarm_cnt)
  );

  or1200_alarm_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .chk_ok(chk_ok), .chk_mask(chk_mask),
    .ack(ack), .alarm(alarm2), .alarm_pulse(alarm_pulse2),
    .fault_vec(fault_vec2), .first_idx(first_idx2),
    .alarm_cnt(alarm_cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ack = 0; chk_mask = 8'h00; chk_ok = 8'hFF;
    rst = 1;
    step();
    rst = 0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    ack = 1; chk_mask = 8'h00; chk_ok = 8'h00; rst = 1;
    step(); step();
    vecs++; if (alarm !== 1'b0) begin errs++; $display("FAIL rst_alarm got=%0h exp=0", alarm); end
    vecs++; if (alarm_pulse !== 1'b0) begin errs++; $display("FAIL rst_pulse got=%0h exp=0", alarm_pulse); end
    vecs++; if (fault_vec !== 8'h00) begin errs++; $display("FAIL rst_fault got=%0h exp=0", fault_vec); end
    vecs++; if (first_idx !== 3'd0) begin errs++; $display("FAIL rst_idx got=%0h exp=0", first_idx); end
    vecs++; if (alarm_cnt !== 8'd0) begin errs++; $display("FAIL rst_cnt got=%0h exp=0", alarm_cnt); end
    ack = 0;
  endtask

  task automatic test_boot();
    rst = 0; chk_ok = 8'h00;
    for (int c = 1; c <= 6; c++) begin
      step();
      vecs++;
      if (alarm !== (c == 6)) begin
        errs++; $display("FAIL boot_alarm c=%0d got=%0h exp=%0h", c, alarm, (c == 6));
      end
    end
    vecs++; if (alarm_pulse !== 1'b1) begin errs++; $display("FAIL boot_pulse got=%0h exp=1", alarm_pulse); end
    vecs++; if (fault_vec !== 8'hFF) begin errs++; $display("FAIL boot_fault got=%0h exp=ff", fault_vec); end
    vecs++; if (first_idx !== 3'd0) begin errs++; $display("FAIL boot_idx got=%0h exp=0", first_idx); end
    vecs++; if (alarm_cnt !== 8'd1) begin errs++; $display("FAIL boot_cnt got=%0h exp=1", alarm_cnt); end
  endtask

  task automatic test_persist();
    do_reset();
    chk_ok = 8'hF7; step();
    chk_ok = 8'hFF; step();
    vecs++; if (alarm !== 1'b0) begin errs++; $display("FAIL pers_single got=%0h exp=0", alarm); end
    chk_ok = 8'hF7; step();
    vecs++; if (alarm !== 1'b0) begin errs++; $display("FAIL pers_first got=%0h exp=0", alarm); end
    step();
    vecs++; if (alarm !== 1'b1) begin errs++; $display("FAIL pers_alarm got=%0h exp=1", alarm); end
    vecs++; if (alarm_pulse !== 1'b1) begin errs++; $display("FAIL pers_pulse got=%0h exp=1", alarm_pulse); end
    vecs++; if (fault_vec !== 8'h08) begin errs++; $display("FAIL pers_fault got=%0h exp=08", fault_vec); end
    vecs++; if (first_idx !== 3'd3) begin errs++; $display("FAIL pers_idx got=%0h exp=3", first_idx); end
    vecs++; if (alarm_cnt !== 8'd1) begin errs++; $display("FAIL pers_cnt got=%0h exp=1", alarm_cnt); end
    chk_ok = 8'hFF; step();
    vecs++; if (alarm_pulse !== 1'b0) begin errs++; $display("FAIL pers_pulse_end got=%0h exp=0", alarm_pulse); end
    vecs++; if (alarm !== 1'b1) begin errs++; $display("FAIL pers_hold got=%0h exp=1", alarm); end
  endtask

  task automatic test_priority();
    do_reset();
    chk_ok = 8'hDB; step(); step();
    vecs++; if (first_idx !== 3'd2) begin errs++; $display("FAIL prio_idx got=%0h exp=2", first_idx); end
    vecs++; if (fault_vec !== 8'h24) begin errs++; $display("FAIL prio_fault got=%0h exp=24", fault_vec); end
    chk_ok = 8'h5B; step();
    vecs++; if (fault_vec !== 8'h24) begin errs++; $display("FAIL prio_early got=%0h exp=24", fault_vec); end
    step();
    vecs++; if (fault_vec !== 8'hA4) begin errs++; $display("FAIL prio_accum got=%0h exp=a4", fault_vec); end
    vecs++; if (first_idx !== 3'd2) begin errs++; $display("FAIL prio_idx_keep got=%0h exp=2", first_idx); end
    vecs++; if (alarm_pulse !== 1'b0) begin errs++; $display("FAIL prio_pulse got=%0h exp=0", alarm_pulse); end
    vecs++; if (alarm_cnt !== 8'd1) begin errs++; $display("FAIL prio_cnt got=%0h exp=1", alarm_cnt); end
  endtask

  task automatic test_ack();
    do_reset();
    chk_ok = 8'hFE; step(); step();
    chk_ok = 8'hFF; ack = 1; step();
    vecs++; if (alarm !== 1'b0) begin errs++; $display("FAIL ack_alarm got=%0h exp=0", alarm); end
    vecs++; if (fault_vec !== 8'h00) begin errs++; $display("FAIL ack_fault got=%0h exp=0", fault_vec); end
    ack = 0; chk_ok = 8'hFB; step(); step();
    vecs++; if (alarm_cnt !== 8'd2) begin errs++; $display("FAIL ack_cnt2 got=%0h exp=2", alarm_cnt); end
    vecs++; if (first_idx !== 3'd2) begin errs++; $display("FAIL ack_idx got=%0h exp=2", first_idx); end
    chk_ok = 8'hFD; step();
    ack = 1; step();
    vecs++; if (alarm !== 1'b1) begin errs++; $display("FAIL ack_coinc_alarm got=%0h exp=1", alarm); end
    vecs++; if (fault_vec !== 8'h06) begin errs++; $display("FAIL ack_coinc_fault got=%0h exp=06", fault_vec); end
    vecs++; if (alarm_cnt !== 8'd2) begin errs++; $display("FAIL ack_coinc_cnt got=%0h exp=2", alarm_cnt); end
    vecs++; if (alarm_pulse !== 1'b0) begin errs++; $display("FAIL ack_coinc_pulse got=%0h exp=0", alarm_pulse); end
    chk_ok = 8'hFF; step(); step();
    vecs++; if (alarm !== 1'b0) begin errs++; $display("FAIL ack_armed got=%0h exp=0", alarm); end
    vecs++; if (alarm_cnt !== 8'd2) begin errs++; $display("FAIL ack_armed_cnt got=%0h exp=2", alarm_cnt); end
    ack = 0;
  endtask

  task automatic test_mask();
    do_reset();
    chk_mask = 8'h01; chk_ok = 8'hFE;
    repeat (4) step();
    vecs++; if (alarm !== 1'b0) begin errs++; $display("FAIL mask_alarm got=%0h exp=0", alarm); end
    chk_mask = 8'h00; step(); step();
    vecs++; if (fault_vec !== 8'h01) begin errs++; $display("FAIL mask_fault got=%0h exp=01", fault_vec); end
    chk_mask = 8'h01; step();
    vecs++; if (fault_vec !== 8'h01) begin errs++; $display("FAIL mask_sticky got=%0h exp=01", fault_vec); end
    vecs++; if (alarm !== 1'b1) begin errs++; $display("FAIL mask_hold got=%0h exp=1", alarm); end
    chk_mask = 8'h00; chk_ok = 8'hFF;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int r = 0; r < 5; r++) begin
      chk_ok = 8'hFE; step(); step();
      chk_ok = 8'hFF; ack = 1; step();
      ack = 0;
    end
    vecs++; if (alarm_cnt2 !== 2'd3) begin errs++; $display("FAIL sat_cnt got=%0h exp=3", alarm_cnt2); end
    vecs++; if (alarm_cnt !== 8'd5) begin errs++; $display("FAIL wide_cnt got=%0h exp=5", alarm_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    chk_ok = 8'h00; step(); step();
    vecs++; if (alarm !== 1'b1) begin errs++; $display("FAIL mid_pre got=%0h exp=1", alarm); end
    rst = 1; ack = 1; step();
    vecs++; if (alarm !== 1'b0) begin errs++; $display("FAIL mid_alarm got=%0h exp=0", alarm); end
    vecs++; if (fault_vec !== 8'h00) begin errs++; $display("FAIL mid_fault got=%0h exp=0", fault_vec); end
    vecs++; if (alarm_cnt !== 8'd0) begin errs++; $display("FAIL mid_cnt got=%0h exp=0", alarm_cnt); end
    vecs++; if (first_idx !== 3'd0) begin errs++; $display("FAIL mid_idx got=%0h exp=0", first_idx); end
    rst = 0; ack = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      vecs++;
      if (alarm !== (c == 6)) begin
        errs++; $display("FAIL mid_boot c=%0d got=%0h exp=%0h", c, alarm, (c == 6));
      end
    end
  endtask

  initial begin
    rst = 1; ack = 0; chk_ok = 8'hFF; chk_mask = 8'h00;
    test_reset();
    test_boot();
    test_persist();
    test_priority();
    test_ack();
    test_mask();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/or1200_alarm_ctrl.md
OR1200_ALARM_CTRL -- requirements
Module: or1200_alarm_ctrl

Interface
REQ-001 SHALL have parameter NUM_CHK, default 8: number of checker result channels (1..32).
REQ-002 SHALL have parameter PERSIST, default 2: consecutive failing samples that qualify a fault (1..15).
REQ-003 SHALL have parameter BOOT_CYC, default 4: cycles after reset during which checks are ignored (0..255).
REQ-004 SHALL have parameter CNT_W, default 8: width of the alarm event counter.
REQ-005 SHALL have a single clock, clk, with reset rst synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 chk_ok  input  NUM_CHK  per-channel assertion result; 1 = pass, 0 = fail.
REQ-009 chk_mask  input  NUM_CHK  per-channel disable; 1 = channel ignored.
REQ-010 ack  input  1  software/debug acknowledge; clears a latched alarm.
REQ-011 alarm  output  1  registered, level alarm (held until acknowledged).
REQ-012 alarm_pulse  output  1  registered, one-cycle strobe on each entry to ALARM.
REQ-013 fault_vec  output  NUM_CHK  sticky record of qualified faulting channels.
REQ-014 first_idx  output  max(1,clog2(NUM_CHK))  index of the channel that caused entry to ALARM.
REQ-015 alarm_cnt  output  CNT_W  saturating count of ALARM entries since reset.

Function
REQ-016 Active fail for channel i SHALL be chk_ok[i]=0 and chk_mask[i]=0.
REQ-017 Each channel SHALL keep a persistence counter that increments on active fail, saturates at PERSIST, and clears to 0 on pass or mask.
REQ-018 Channel i SHALL be qualified in a cycle when it is in active fail and its counter equals PERSIST-1 or more; with PERSIST=1, every active fail qualifies.
REQ-019 The FSM SHALL have three states, BOOT, ARMED and ALARM; reset enters BOOT.
REQ-020 BOOT SHALL last exactly BOOT_CYC cycles and then go to ARMED; BOOT_CYC=0 goes to ARMED on the first cycle after reset; persistence counters SHALL hold 0 in BOOT.
REQ-021 In ARMED, any qualified channel SHALL cause ALARM on the next edge, so alarm rises the cycle after the PERSIST-th consecutive failing sample.
REQ-022 On entry to ALARM, the block SHALL, in the same edge: set fault_vec |= qualified, load first_idx with the lowest qualified index, pulse alarm_pulse, and increment alarm_cnt (saturating at all-ones).
REQ-023 In ALARM, fault_vec SHALL keep accumulating newly qualified channels; first_idx, alarm_pulse and alarm_cnt SHALL NOT change.
REQ-024 ack in ALARM with no qualified channel that cycle SHALL return the FSM to ARMED and clear fault_vec and first_idx on the same edge.
REQ-025 ack in ALARM coincident with a qualified channel SHALL be ignored: stay in ALARM, OR in the new bits, no pulse, no count.
REQ-026 ack in BOOT or ARMED SHALL have no effect.
REQ-027 Asserting mask on a channel SHALL clear its persistence counter but SHALL NOT clear a set fault_vec bit.
REQ-028 alarm SHALL be 1 exactly when the state is ALARM.

Reset
REQ-029 rst SHALL set: state BOOT, boot counter 0, all persistence counters 0, alarm 0, alarm_pulse 0, fault_vec 0, first_idx 0, alarm_cnt 0.
REQ-030 rst asserted mid-alarm SHALL take priority over ack and all fails, and SHALL restart the BOOT window.

Structure
REQ-031 State encodings (BOOT/ARMED/ALARM) and default parameter constants SHALL live in a shared or1200_chk_pkg.
REQ-032 The per-channel persistence counter SHALL be a sub-module, or1200_alarm_persist, instantiated NUM_CHK times via generate.
REQ-033 The lowest-index priority encoder for first_idx SHALL be a function in or1200_chk_pkg.

Verification
REQ-034 Boot: defaults, rst then chk_ok=8'h00 for 4 cycles -> alarm stays 0; alarm rises in cycle 6 after reset release (PERSIST=2).
REQ-035 Persistence: chk_ok[3]=0 for 1 cycle, then 1 -> no alarm; chk_ok[3]=0 for 2 cycles -> alarm=1, alarm_pulse 1 cycle, fault_vec=8'h08, first_idx=3, alarm_cnt=1.
REQ-036 Priority/accumulate: channels 5 and 2 qualify in the same cycle -> first_idx=2, fault_vec=8'h24; channel 7 qualifies later -> fault_vec=8'hA4, first_idx still 2.
REQ-037 Ack: ack with all channels passing -> alarm=0, fault_vec=0 next cycle; ack coincident with channel 1 qualifying -> alarm stays 1, fault_vec gains bit 1, alarm_cnt unchanged.
REQ-038 Mask/saturation: chk_mask[0]=1 with chk_ok[0]=0 held -> no alarm; CNT_W=2 with 5 alarm/ack rounds -> alarm_cnt=3.
REQ-039 Reset mid-alarm: rst while in ALARM with ack=1 -> all outputs 0 next cycle and BOOT window restarts.
